// File: rtl/conv3x3_writer.sv
// conv3x3_writer: convolves each accepted 3x3 window with a fixed kernel, normalizes, clamps and writes one pixel per window.
module conv3x3_writer #(
  parameter int IMAGE_WIDTH = 130,
  parameter int IMAGE_HEIGHT = 130,
  parameter int OUT_ADDR_W = 14,
  parameter logic signed [7:0] K0 = 8'sd1,
  parameter logic signed [7:0] K1 = 8'sd2,
  parameter logic signed [7:0] K2 = 8'sd1,
  parameter logic signed [7:0] K3 = 8'sd2,
  parameter logic signed [7:0] K4 = 8'sd4,
  parameter logic signed [7:0] K5 = 8'sd2,
  parameter logic signed [7:0] K6 = 8'sd1,
  parameter logic signed [7:0] K7 = 8'sd2,
  parameter logic signed [7:0] K8 = 8'sd1,
  parameter int SHIFT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic [7:0] window [8:0],
  output logic out_we,
  output logic [OUT_ADDR_W-1:0] out_addr,
  output logic [7:0] out_data,
  output logic frame_done
);
  localparam int N_OUT = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2);
  localparam logic [OUT_ADDR_W-1:0] LAST = OUT_ADDR_W'(N_OUT - 1);
  localparam logic signed [7:0] KC [9] = '{K0, K1, K2, K3, K4, K5, K6, K7, K8};
  logic [7:0] w [8:0];
  logic signed [16:0] p_c [9];
  logic signed [16:0] p [9];
  logic signed [20:0] s_c, s, r;
  logic [7:0] clamp;
  logic v0, v1, v2;
  logic [OUT_ADDR_W-1:0] cnt;
  always_comb begin
    s_c = '0;
    for (int i = 0; i < 9; i++) begin
      p_c[i] = 17'(KC[i]) * 17'($signed({1'b0, w[i]}));
      s_c = s_c + 21'(p[i]);
    end
  end
  assign r = s >>> SHIFT;
  assign clamp = r < 0 ? 8'd0 : (r > 21'sd255 ? 8'd255 : r[7:0]);
  // Data registers load only under their stage valid, so bubbles never disturb in-flight values.
  always_ff @(posedge clk) begin
    if (!stall) w <= window;
    if (v0) p <= p_c;
    if (v1) s <= s_c;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_we <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      frame_done <= 1'b0;
      cnt <= '0;
    end else begin
      v0 <= !stall;
      v1 <= v0;
      v2 <= v1;
      out_we <= v2;
      frame_done <= v2 && cnt == LAST;
      if (v2) begin
        out_addr <= cnt;
        out_data <= clamp;
        cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_writer.sv
// tb_conv3x3_writer: scoreboard bench for conv3x3_writer with Gaussian and Laplacian instances.
module tb_conv3x3_writer;
  localparam int N = 16384;
  typedef struct {
    int cyc;
    logic [13:0] addr;
    logic [7:0] data;
    logic fd;
  } exp_t;
  logic clk = 0, reset = 1, stall_g = 1, stall_l = 1;
  logic [7:0] win_g [8:0], win_l [8:0], pat [8:0];
  logic we_g, we_l, fd_g, fd_l;
  logic [13:0] addr_g, addr_l, ag = 0, al = 0;
  logic [7:0] data_g, data_l;
  exp_t qg[$], ql[$];
  int cyc = 0, n_chk = 0, n_fail = 0, fd_cnt = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  conv3x3_writer u_gau (
    .clk(clk), .reset(reset), .stall(stall_g), .window(win_g),
    .out_we(we_g), .out_addr(addr_g), .out_data(data_g), .frame_done(fd_g)
  );
  conv3x3_writer #(
    .K0(8'sd0), .K1(-8'sd1), .K2(8'sd0), .K3(-8'sd1), .K4(8'sd4),
    .K5(-8'sd1), .K6(8'sd0), .K7(-8'sd1), .K8(8'sd0), .SHIFT(0)
  ) u_lap (
    .clk(clk), .reset(reset), .stall(stall_l), .window(win_l),
    .out_we(we_l), .out_addr(addr_l), .out_data(data_l), .frame_done(fd_l)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  task automatic mon(input bit l, input logic we, input logic [13:0] a, input logic [7:0] d, input logic f);
    exp_t e;
    bit has = 0;
    string nm = l ? "lap" : "gau";
    if (l) begin
      if (ql.size() != 0 && ql[0].cyc == cyc) begin e = ql.pop_front(); has = 1; end
    end else begin
      if (qg.size() != 0 && qg[0].cyc == cyc) begin e = qg.pop_front(); has = 1; end
    end
    chk({nm, " we"}, 32'(we), 32'(has));
    if (has) begin
      chk({nm, " addr"}, 32'(a), 32'(e.addr));
      chk({nm, " data"}, 32'(d), 32'(e.data));
      chk({nm, " frame_done"}, 32'(f), 32'(e.fd));
    end else chk({nm, " idle frame_done"}, 32'(f), 0);
  endtask
  always @(posedge clk) begin
    #2;
    mon(0, we_g, addr_g, data_g, fd_g);
    mon(1, we_l, addr_l, data_l, fd_l);
    if (fd_g === 1'b1) fd_cnt++;
  end
  task automatic junk();
    for (int i = 0; i < 9; i++) begin
      win_g[i] = 8'($urandom);
      win_l[i] = 8'($urandom);
    end
  endtask
  task automatic uni(input logic [7:0] v);
    for (int i = 0; i < 9; i++) pat[i] = v;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 junk();
    end
  endtask
  task automatic send(input bit l, input logic [7:0] ed, input bit push);
    if (l) begin stall_l = 0; win_l = pat; end
    else begin stall_g = 0; win_g = pat; end
    @(posedge clk);
    #1;
    if (push && l) begin
      ql.push_back('{cyc + 3, al, ed, al == 14'(N - 1)});
      al = al == 14'(N - 1) ? 14'd0 : al + 14'd1;
    end else if (push) begin
      qg.push_back('{cyc + 3, ag, ed, ag == 14'(N - 1)});
      ag = ag == 14'(N - 1) ? 14'd0 : ag + 14'd1;
    end
    stall_g = 1;
    stall_l = 1;
    junk();
  endtask
  task automatic zero_chk();
    chk("rst gau we", 32'(we_g), 0);
    chk("rst gau addr", 32'(addr_g), 0);
    chk("rst gau data", 32'(data_g), 0);
    chk("rst gau frame_done", 32'(fd_g), 0);
    chk("rst lap we", 32'(we_l), 0);
  endtask
  task automatic do_reset(input int n);
    reset = 1;
    stall_g = 0;
    stall_l = 0;
    repeat (n) begin
      @(posedge clk);
      #1 junk();
      zero_chk();
    end
    reset = 0;
    stall_g = 1;
    stall_l = 1;
    ag = 0;
    al = 0;
    repeat (3) begin
      @(posedge clk);
      #1 zero_chk();
    end
  endtask
  initial begin
    junk();
    do_reset(2);
    uni(100); send(0, 100, 1);
    idle(5);
    uni(0); pat[4] = 255; send(0, 63, 1);
    uni(0); pat[0] = 255; pat[2] = 255; pat[6] = 255; pat[8] = 255; send(0, 63, 1);
    for (int i = 0; i < 9; i++) pat[i] = 8'((i + 1) * 10);
    send(0, 50, 1);
    idle(5);
    do_reset(2);
    uni(20); send(0, 20, 1);
    idle(2);
    uni(30); send(0, 30, 1);
    uni(40); send(0, 40, 1);
    uni(255); pat[4] = 0; send(1, 0, 1);
    uni(0); pat[4] = 255; send(1, 255, 1);
    uni(90); pat[4] = 100; send(1, 40, 1);
    idle(5);
    uni(77); send(0, 0, 0); send(0, 0, 0);
    do_reset(1);
    uni(9); send(0, 9, 1);
    idle(5);
    do_reset(1);
    for (int i = 0; i < N; i++) begin
      uni(8'(i)); send(0, 8'(i), 1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    uni(5); send(0, 5, 1);
    idle(6);
    chk("frame_done pulses", 32'(fd_cnt), 1);
    chk("gau queue drained", 32'(qg.size()), 0);
    chk("lap queue drained", 32'(ql.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
